rs_alu_param: RTL and testbench
===============================

Name: rs_alu_param

Overview:
- Parametrised ALU reservation station. Successor to the fixed 8-entry, 2-in/2-out ALU RS.
- Accepts up to DISP_W renamed ALU ops per cycle from the decoder/dispatch stage.
- Wakes operands from CDB_N result broadcast channels.
- Selects up to ISSUE_W ready entries per cycle internally, oldest-first, and drives them to the ex_alu units through registered outputs.
- Adds three things the previous generation lacked: internal age-ordered select, same-cycle CDB capture at dispatch, and flush/backpressure.

Parameters:
- DEPTH, 8: number of entries (2..32).
- DISP_W, 2: dispatch ports.
- ISSUE_W, 2: issue ports.
- CDB_N, 3: broadcast channels. Lower index wins on duplicate tag.
- DATA_W, 32: operand width.
- ADDR_W, 32: PC width.
- TAG_W, 5: ROB tag width.
- TAG_FREE, 0: tag value meaning "operand valid".
- OP_W, 6: ALU opcode width.
- REG_W, 5: architectural destination register width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rdy  in  1  global enable. Low holds all state and outputs.
- flush  in  1  mispredict flush. Synchronous; clears all entries.
- disp_valid  in  DISP_W  per-port op valid.
- disp_op  in  DISP_W*OP_W  opcode.
- disp_data1, disp_data2  in  DISP_W*DATA_W  operand values.
- disp_tag1, disp_tag2  in  DISP_W*TAG_W  operand tags.
- disp_pc  in  DISP_W*ADDR_W  PC.
- disp_dest  in  DISP_W*TAG_W  ROB tag of result.
- disp_reg  in  DISP_W*REG_W  destination register.
- disp_ready  out  1  high when free entries >= DISP_W.
- cdb_valid  in  CDB_N  broadcast valid.
- cdb_tag  in  CDB_N*TAG_W  broadcast tag.
- cdb_data  in  CDB_N*DATA_W  broadcast data.
- iss_stall  in  1  ex_alu backpressure.
- iss_valid  out  ISSUE_W  registered issue valid.
- iss_src1, iss_src2  out  ISSUE_W*DATA_W  issued operands.
- iss_pc  out  ISSUE_W*ADDR_W  issued PC.
- iss_op  out  ISSUE_W*OP_W  issued opcode.
- iss_dest  out  ISSUE_W*TAG_W  issued ROB tag.
- iss_reg  out  ISSUE_W*REG_W  issued destination register.
- free_cnt  out  $clog2(DEPTH+1)  number of non-busy entries.

Behaviour:
- Reset (rst high, asynchronous):
  - busy=0 and age matrix=0.
  - iss_valid=0; iss_src1/iss_src2/iss_pc/iss_op/iss_reg=0; iss_dest=TAG_FREE.
  - free_cnt=DEPTH; disp_ready=1 (given DISP_W<=DEPTH).
- All updates below occur only when rdy=1. With rdy=0, state and outputs hold.
- Dispatch:
  - Accepted when disp_ready & !flush.
  - Valid ports take the lowest-index free entries, in ascending port order; invalid ports consume no entry.
  - disp_ready is combinational from current busy and does not credit same-cycle issue frees.
  - Dispatch with disp_ready=0 is ignored; the upstream stage must hold.
- Wakeup:
  - Each cycle, every busy entry with tag!=TAG_FREE compares against all valid CDB channels.
  - On a match it latches cdb_data and sets its tag to TAG_FREE.
  - The same compare applies to dispatching operands, so an op dispatched in the cycle its producer broadcasts enters already woken.
- Ready: busy & post-wakeup tag1==TAG_FREE & tag2==TAG_FREE. A broadcast in cycle N makes the entry selectable in cycle N, with operands bypassed from the CDB.
- Age:
  - DEPTH x DEPTH older matrix. On allocation, row[e] marks every currently busy entry as older.
  - Among same-cycle dispatches, a lower port is older.
  - Entries allocated in the current cycle are not selectable until the next cycle.
- Select:
  - When !iss_stall & !flush, pick up to ISSUE_W ready entries, oldest first.
  - Issue port k gets the k-th oldest ready entry.
- Issue:
  - Selected entries are registered onto the iss_* outputs at the clock edge (1-cycle latency), and their busy bits clear at that same edge.
  - Unused ports get iss_valid=0, data=0, iss_dest=TAG_FREE.
  - iss_stall=1 means no select this cycle; iss_valid=0 next cycle and entries stay in place.
- Flush: at the edge, busy=0 and iss_valid=0. Same-cycle dispatch and select are discarded. free_cnt=DEPTH next cycle.
- Simultaneous free+alloc of one index cannot occur, because allocation uses only pre-edge free entries.

Decomposition:
- Shared package rs_pkg holds:
  - the TAG_FREE constant and ALU NOP opcode;
  - the dispatch-entry struct {op,data1,tag1,data2,tag2,pc,dest,reg};
  - a CDB channel struct;
  - helper functions: lowest-free priority encoder and popcount.
- Sub-module rs_alu_param_ent: one entry holding its operand registers and CDB wakeup compare. Outputs ready plus bypassed src1/src2.
- Age matrix and oldest-k select stay in the top level.

Test Plan:
- Reset mid-stream: with rst asserted asynchronously, iss_valid=0 and free_cnt=8 immediately, without waiting for an edge.
- Age order: dispatch independent ops A,B (tags free) then C,D. Next cycles issue A,B on ports 0,1, then C,D.
- Same-cycle CDB capture: dispatch tag1=7 while cdb_valid[1]=1, cdb_tag=7, cdb_data=0x1234. Op issues next cycle with iss_src1=0x1234.
- Fill to full: 8 dispatches give free_cnt=0 and disp_ready=0. Dispatch attempts are ignored. One issue raises free_cnt to 1 but disp_ready stays 0 (DISP_W=2).
- Duplicate tag: cdb 0 and 2 both broadcast tag 3 with data 0xA and 0xB. Waiting operand takes 0xA.
- Flush with iss_stall toggling: 5 busy entries plus a dispatch in the flush cycle give free_cnt=8 and iss_valid=0 next cycle. iss_stall=1 holds 2 ready entries; they issue the cycle after it drops.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared constants, default-width record layouts and select helpers for the
// parametrised ALU reservation station.
package rs_pkg;

   localparam int unsigned RS_TAG_FREE = 0;
   localparam int unsigned RS_ALU_NOP  = 0;

   // Record layouts of the default 32-bit / 5-bit-tag configuration
   typedef struct packed {
      logic [5:0]  op;
      logic [31:0] data1;
      logic [4:0]  tag1;
      logic [31:0] data2;
      logic [4:0]  tag2;
      logic [31:0] pc;
      logic [4:0]  dest;
      logic [4:0]  dst_reg;
   } rs_disp_t;

   typedef struct packed {
      logic        valid;
      logic [4:0]  tag;
      logic [31:0] data;
   } rs_cdb_t;

   // One-hot of the lowest set bit (lowest free entry when fed the free mask)
   function automatic logic [31:0] lowest_free(input logic [31:0] v);
      return v & (~v + 32'd1);
   endfunction

   function automatic logic [5:0] popcnt(input logic [31:0] v);
      logic [5:0] c;
      c = '0;
      for (int unsigned i = 0; i < 32; i++) c = c + {5'b0, v[i]};
      return c;
   endfunction

endpackage

// File: rtl/rs_alu_param_ent.sv
// One reservation-station entry: operand/payload registers and CDB wakeup,
// with the woken operands bypassed straight to the select/issue path.
module rs_alu_param_ent
   import rs_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned TAG_W    = 5,
   parameter int unsigned OP_W     = 6,
   parameter int unsigned REG_W    = 5,
   parameter int unsigned CDB_N    = 3,
   parameter int unsigned TAG_FREE = RS_TAG_FREE
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      busy,
   input  logic                      alloc,
   input  logic [OP_W-1:0]           new_op,
   input  logic [DATA_W-1:0]         new_data1,
   input  logic [TAG_W-1:0]          new_tag1,
   input  logic [DATA_W-1:0]         new_data2,
   input  logic [TAG_W-1:0]          new_tag2,
   input  logic [ADDR_W-1:0]         new_pc,
   input  logic [TAG_W-1:0]          new_dest,
   input  logic [REG_W-1:0]          new_reg,
   input  logic [CDB_N-1:0]          cdb_valid,
   input  logic [CDB_N*TAG_W-1:0]    cdb_tag,
   input  logic [CDB_N*DATA_W-1:0]   cdb_data,
   output logic                      ready,
   output logic [DATA_W-1:0]         src1,
   output logic [DATA_W-1:0]         src2,
   output logic [OP_W-1:0]           op,
   output logic [ADDR_W-1:0]         pc,
   output logic [TAG_W-1:0]          dest,
   output logic [REG_W-1:0]          dst_reg
);

   localparam logic [TAG_W-1:0] TFREE = TAG_W'(TAG_FREE);

   logic [DATA_W-1:0] data1_q, data2_q, w_data1, w_data2;
   logic [TAG_W-1:0]  tag1_q, tag2_q, w_tag1, w_tag2;
   logic [OP_W-1:0]   op_q;
   logic [ADDR_W-1:0] pc_q;
   logic [TAG_W-1:0]  dest_q;
   logic [REG_W-1:0]  reg_q;

   // Dispatching operands go through the same compare; first hit (lowest channel) wins
   always_comb begin
      w_tag1  = alloc ? new_tag1  : tag1_q;
      w_data1 = alloc ? new_data1 : data1_q;
      w_tag2  = alloc ? new_tag2  : tag2_q;
      w_data2 = alloc ? new_data2 : data2_q;
      for (int unsigned c = 0; c < CDB_N; c++) begin
         if (w_tag1 != TFREE && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == w_tag1) begin
            w_data1 = cdb_data[c*DATA_W +: DATA_W];
            w_tag1  = TFREE;
         end
         if (w_tag2 != TFREE && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == w_tag2) begin
            w_data2 = cdb_data[c*DATA_W +: DATA_W];
            w_tag2  = TFREE;
         end
      end
   end

   assign ready   = busy && (w_tag1 == TFREE) && (w_tag2 == TFREE);
   assign src1    = w_data1;
   assign src2    = w_data2;
   assign op      = op_q;
   assign pc      = pc_q;
   assign dest    = dest_q;
   assign dst_reg = reg_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data1_q <= '0;
         data2_q <= '0;
         tag1_q  <= TFREE;
         tag2_q  <= TFREE;
         op_q    <= '0;
         pc_q    <= '0;
         dest_q  <= TFREE;
         reg_q   <= '0;
      end else if (rdy) begin
         data1_q <= w_data1;
         data2_q <= w_data2;
         tag1_q  <= w_tag1;
         tag2_q  <= w_tag2;
         if (alloc) begin
            op_q   <= new_op;
            pc_q   <= new_pc;
            dest_q <= new_dest;
            reg_q  <= new_reg;
         end
      end
   end

endmodule

// File: rtl/rs_alu_param.sv
// Parametrised ALU reservation station: lowest-free allocation, CDB wakeup,
// age-matrix oldest-first select and registered issue with flush/stall.
module rs_alu_param
   import rs_pkg::*;
#(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned DISP_W   = 2,
   parameter int unsigned ISSUE_W  = 2,
   parameter int unsigned CDB_N    = 3,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned TAG_W    = 5,
   parameter int unsigned TAG_FREE = RS_TAG_FREE,
   parameter int unsigned OP_W     = 6,
   parameter int unsigned REG_W    = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rdy,
   input  logic                        flush,
   input  logic [DISP_W-1:0]           disp_valid,
   input  logic [DISP_W*OP_W-1:0]      disp_op,
   input  logic [DISP_W*DATA_W-1:0]    disp_data1,
   input  logic [DISP_W*DATA_W-1:0]    disp_data2,
   input  logic [DISP_W*TAG_W-1:0]     disp_tag1,
   input  logic [DISP_W*TAG_W-1:0]     disp_tag2,
   input  logic [DISP_W*ADDR_W-1:0]    disp_pc,
   input  logic [DISP_W*TAG_W-1:0]     disp_dest,
   input  logic [DISP_W*REG_W-1:0]     disp_reg,
   output logic                        disp_ready,
   input  logic [CDB_N-1:0]            cdb_valid,
   input  logic [CDB_N*TAG_W-1:0]      cdb_tag,
   input  logic [CDB_N*DATA_W-1:0]     cdb_data,
   input  logic                        iss_stall,
   output logic [ISSUE_W-1:0]          iss_valid,
   output logic [ISSUE_W*DATA_W-1:0]   iss_src1,
   output logic [ISSUE_W*DATA_W-1:0]   iss_src2,
   output logic [ISSUE_W*ADDR_W-1:0]   iss_pc,
   output logic [ISSUE_W*OP_W-1:0]     iss_op,
   output logic [ISSUE_W*TAG_W-1:0]    iss_dest,
   output logic [ISSUE_W*REG_W-1:0]    iss_reg,
   output logic [$clog2(DEPTH+1)-1:0]  free_cnt
);

   localparam int unsigned      CNT_W = $clog2(DEPTH+1);
   localparam logic [TAG_W-1:0] TFREE = TAG_W'(TAG_FREE);

   logic [DEPTH-1:0]  busy, busy_nxt, alloc, ready, issued, avail, taken, oh;
   logic [DEPTH-1:0]  older [DEPTH];
   logic [DEPTH-1:0]  older_nxt [DEPTH];
   logic [DEPTH-1:0]  alloc_row [DEPTH];
   logic [DISP_W-1:0] port_sel [DEPTH];
   logic [5:0]        rank [DEPTH];

   logic [OP_W-1:0]   n_op [DEPTH];
   logic [DATA_W-1:0] n_data1 [DEPTH];
   logic [DATA_W-1:0] n_data2 [DEPTH];
   logic [TAG_W-1:0]  n_tag1 [DEPTH];
   logic [TAG_W-1:0]  n_tag2 [DEPTH];
   logic [ADDR_W-1:0] n_pc [DEPTH];
   logic [TAG_W-1:0]  n_dest [DEPTH];
   logic [REG_W-1:0]  n_reg [DEPTH];

   logic [DATA_W-1:0] e_src1 [DEPTH];
   logic [DATA_W-1:0] e_src2 [DEPTH];
   logic [OP_W-1:0]   e_op [DEPTH];
   logic [ADDR_W-1:0] e_pc [DEPTH];
   logic [TAG_W-1:0]  e_dest [DEPTH];
   logic [REG_W-1:0]  e_reg [DEPTH];

   logic [ISSUE_W-1:0]        pick_valid;
   logic [ISSUE_W*DATA_W-1:0] pick_src1, pick_src2;
   logic [ISSUE_W*ADDR_W-1:0] pick_pc;
   logic [ISSUE_W*OP_W-1:0]   pick_op;
   logic [ISSUE_W*TAG_W-1:0]  pick_dest;
   logic [ISSUE_W*REG_W-1:0]  pick_reg;

   logic disp_ok, sel_en;

   assign free_cnt   = CNT_W'(DEPTH) - CNT_W'(popcnt(32'(busy)));
   assign disp_ready = 32'(free_cnt) >= DISP_W;
   assign disp_ok    = disp_ready && !flush;
   assign sel_en     = !iss_stall && !flush;

   // Allocation: each valid port takes the next lowest free entry; the new row
   // marks pre-edge busy entries plus lower-port same-cycle allocations as older
   always_comb begin
      avail = ~busy;
      taken = '0;
      oh    = '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
         port_sel[e]  = '0;
         alloc_row[e] = '0;
      end
      if (disp_ok) begin
         for (int unsigned p = 0; p < DISP_W; p++) begin
            if (disp_valid[p]) begin
               oh    = DEPTH'(lowest_free(32'(avail)));
               avail = avail & ~oh;
               for (int unsigned e = 0; e < DEPTH; e++) begin
                  if (oh[e]) begin
                     port_sel[e][p] = 1'b1;
                     alloc_row[e]   = busy | taken;
                  end
               end
               taken = taken | oh;
            end
         end
      end
      alloc = taken;
   end

   always_comb begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
         n_op[e]    = '0;
         n_data1[e] = '0;
         n_data2[e] = '0;
         n_tag1[e]  = TFREE;
         n_tag2[e]  = TFREE;
         n_pc[e]    = '0;
         n_dest[e]  = TFREE;
         n_reg[e]   = '0;
         for (int unsigned p = 0; p < DISP_W; p++) begin
            if (port_sel[e][p]) begin
               n_op[e]    = disp_op[p*OP_W +: OP_W];
               n_data1[e] = disp_data1[p*DATA_W +: DATA_W];
               n_data2[e] = disp_data2[p*DATA_W +: DATA_W];
               n_tag1[e]  = disp_tag1[p*TAG_W +: TAG_W];
               n_tag2[e]  = disp_tag2[p*TAG_W +: TAG_W];
               n_pc[e]    = disp_pc[p*ADDR_W +: ADDR_W];
               n_dest[e]  = disp_dest[p*TAG_W +: TAG_W];
               n_reg[e]   = disp_reg[p*REG_W +: REG_W];
            end
         end
      end
   end

   for (genvar e = 0; e < DEPTH; e++) begin : g_ent
      rs_alu_param_ent #(
         .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .OP_W(OP_W),
         .REG_W(REG_W), .CDB_N(CDB_N), .TAG_FREE(TAG_FREE)
      ) u_ent (
         .clk(clk), .rst(rst), .rdy(rdy), .busy(busy[e]), .alloc(alloc[e]),
         .new_op(n_op[e]), .new_data1(n_data1[e]), .new_tag1(n_tag1[e]),
         .new_data2(n_data2[e]), .new_tag2(n_tag2[e]), .new_pc(n_pc[e]),
         .new_dest(n_dest[e]), .new_reg(n_reg[e]),
         .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
         .ready(ready[e]), .src1(e_src1[e]), .src2(e_src2[e]), .op(e_op[e]),
         .pc(e_pc[e]), .dest(e_dest[e]), .dst_reg(e_reg[e])
      );
   end

   // Rank = number of older ready entries; rank k goes to issue port k
   always_comb begin
      pick_valid = '0;
      pick_src1  = '0;
      pick_src2  = '0;
      pick_pc    = '0;
      pick_op    = {ISSUE_W{OP_W'(RS_ALU_NOP)}};
      pick_dest  = {ISSUE_W{TFREE}};
      pick_reg   = '0;
      issued     = '0;
      for (int unsigned e = 0; e < DEPTH; e++) rank[e] = popcnt(32'(ready & older[e]));
      if (sel_en) begin
         for (int unsigned k = 0; k < ISSUE_W; k++) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
               if (ready[e] && rank[e] == 6'(k)) begin
                  pick_valid[k]                = 1'b1;
                  pick_src1[k*DATA_W +: DATA_W] = e_src1[e];
                  pick_src2[k*DATA_W +: DATA_W] = e_src2[e];
                  pick_pc[k*ADDR_W +: ADDR_W]   = e_pc[e];
                  pick_op[k*OP_W +: OP_W]       = e_op[e];
                  pick_dest[k*TAG_W +: TAG_W]   = e_dest[e];
                  pick_reg[k*REG_W +: REG_W]    = e_reg[e];
                  issued[e]                     = 1'b1;
               end
            end
         end
      end
   end

   // A newly allocated entry is younger than everything: clear its column first
   always_comb begin
      busy_nxt = (busy & ~issued) | alloc;
      for (int unsigned e = 0; e < DEPTH; e++) older_nxt[e] = older[e];
      for (int unsigned j = 0; j < DEPTH; j++) begin
         if (alloc[j]) begin
            for (int unsigned e = 0; e < DEPTH; e++) older_nxt[e][j] = 1'b0;
         end
      end
      for (int unsigned e = 0; e < DEPTH; e++) begin
         if (alloc[e]) older_nxt[e] = alloc_row[e];
      end
      if (flush) begin
         busy_nxt = '0;
         for (int unsigned e = 0; e < DEPTH; e++) older_nxt[e] = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= '0;
         for (int unsigned e = 0; e < DEPTH; e++) older[e] <= '0;
         iss_valid <= '0;
         iss_src1  <= '0;
         iss_src2  <= '0;
         iss_pc    <= '0;
         iss_op    <= '0;
         iss_dest  <= {ISSUE_W{TFREE}};
         iss_reg   <= '0;
      end else if (rdy) begin
         busy      <= busy_nxt;
         for (int unsigned e = 0; e < DEPTH; e++) older[e] <= older_nxt[e];
         iss_valid <= pick_valid;
         iss_src1  <= pick_src1;
         iss_src2  <= pick_src2;
         iss_pc    <= pick_pc;
         iss_op    <= pick_op;
         iss_dest  <= pick_dest;
         iss_reg   <= pick_reg;
      end
   end

endmodule

// File: tb/tb_rs_alu_param.sv
// Directed bench for rs_alu_param (default parameters: 8 entries, 2 disp, 2 issue, 3 CDB).
module tb_rs_alu_param;

   logic        clk = 1'b0;
   logic        rst, rdy, flush, iss_stall;
   logic [1:0]  disp_valid;
   logic [11:0] disp_op;
   logic [63:0] disp_data1, disp_data2, disp_pc;
   logic [9:0]  disp_tag1, disp_tag2, disp_dest, disp_reg;
   logic        disp_ready;
   logic [2:0]  cdb_valid;
   logic [14:0] cdb_tag;
   logic [95:0] cdb_data;
   logic [1:0]  iss_valid;
   logic [63:0] iss_src1, iss_src2, iss_pc;
   logic [11:0] iss_op;
   logic [9:0]  iss_dest, iss_reg;
   logic [3:0]  free_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   rs_alu_param #(.DEPTH(8), .DISP_W(2), .ISSUE_W(2), .CDB_N(3)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .disp_valid(disp_valid), .disp_op(disp_op), .disp_data1(disp_data1),
      .disp_data2(disp_data2), .disp_tag1(disp_tag1), .disp_tag2(disp_tag2),
      .disp_pc(disp_pc), .disp_dest(disp_dest), .disp_reg(disp_reg),
      .disp_ready(disp_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .cdb_data(cdb_data), .iss_stall(iss_stall), .iss_valid(iss_valid),
      .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_pc(iss_pc), .iss_op(iss_op),
      .iss_dest(iss_dest), .iss_reg(iss_reg), .free_cnt(free_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      disp_valid = '0; disp_op = '0; disp_data1 = '0; disp_data2 = '0;
      disp_tag1 = '0; disp_tag2 = '0; disp_pc = '0; disp_dest = '0; disp_reg = '0;
      cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
      flush = 1'b0; iss_stall = 1'b0; rdy = 1'b1;
   endtask

   // pc = 0x1000 + 4*dest, reg = dest
   task automatic disp_set(input int p, input logic [5:0] op, input logic [31:0] d1,
                           input logic [4:0] t1, input logic [31:0] d2,
                           input logic [4:0] t2, input logic [4:0] dest);
      disp_valid[p]         = 1'b1;
      disp_op[p*6 +: 6]     = op;
      disp_data1[p*32 +: 32] = d1;
      disp_tag1[p*5 +: 5]   = t1;
      disp_data2[p*32 +: 32] = d2;
      disp_tag2[p*5 +: 5]   = t2;
      disp_pc[p*32 +: 32]   = 32'h1000 + 32'(dest) * 4;
      disp_dest[p*5 +: 5]   = dest;
      disp_reg[p*5 +: 5]    = dest;
   endtask

   task automatic cdb_set(input int ch, input logic [4:0] tag, input logic [31:0] data);
      cdb_valid[ch]        = 1'b1;
      cdb_tag[ch*5 +: 5]   = tag;
      cdb_data[ch*32 +: 32] = data;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      n_checks++; if (iss_valid !== 2'b00) begin n_fail++; $display("FAIL reset_iss_valid got=%b exp=00", iss_valid); end
      n_checks++; if (free_cnt !== 4'd8) begin n_fail++; $display("FAIL reset_free_cnt got=%0d exp=8", free_cnt); end
      n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready got=%b exp=1", disp_ready); end
      n_checks++; if (iss_dest !== 10'd0 || iss_src1 !== 64'd0 || iss_op !== 12'd0) begin
         n_fail++; $display("FAIL reset_iss_data got dest=%h src1=%h op=%h exp=0", iss_dest, iss_src1, iss_op); end
      rst = 1'b0;
      step();
   endtask

   // Older entries at higher indices must still win over younger low-index ones
   task automatic test_age_order();
      clear_inputs();
      disp_set(0, 6'd1, 32'h10, 5'd0, 32'h0, 5'd0, 5'd10);
      disp_set(1, 6'd2, 32'h11, 5'd0, 32'h0, 5'd0, 5'd11);
      step();
      clear_inputs();
      disp_set(0, 6'd3, 32'h0, 5'd9, 32'h50, 5'd0, 5'd5);
      disp_set(1, 6'd4, 32'h0, 5'd9, 32'h60, 5'd0, 5'd6);
      step();
      n_checks++; if (iss_valid !== 2'b11) begin n_fail++; $display("FAIL age_xy_valid got=%b exp=11", iss_valid); end
      n_checks++; if (iss_dest !== {5'd11, 5'd10}) begin n_fail++; $display("FAIL age_xy_dest got=%h exp=%h", iss_dest, {5'd11, 5'd10}); end
      n_checks++; if (iss_src1[31:0] !== 32'h10 || iss_op[5:0] !== 6'd1) begin
         n_fail++; $display("FAIL age_xy_payload got src1=%h op=%0d exp=10/1", iss_src1[31:0], iss_op[5:0]); end
      clear_inputs();
      disp_set(0, 6'd5, 32'h70, 5'd0, 32'h0, 5'd0, 5'd7);
      disp_set(1, 6'd6, 32'h80, 5'd0, 32'h0, 5'd0, 5'd8);
      step();
      n_checks++; if (iss_valid !== 2'b00) begin n_fail++; $display("FAIL age_wait_valid got=%b exp=00", iss_valid); end
      n_checks++; if (free_cnt !== 4'd4) begin n_fail++; $display("FAIL age_free4 got=%0d exp=4", free_cnt); end
      clear_inputs();
      cdb_set(0, 5'd9, 32'h99);
      step();
      n_checks++; if (iss_valid !== 2'b11 || iss_dest !== {5'd6, 5'd5}) begin
         n_fail++; $display("FAIL age_pq_dest got v=%b dest=%h exp v=11 dest=%h", iss_valid, iss_dest, {5'd6, 5'd5}); end
      n_checks++; if (iss_src1 !== {32'h99, 32'h99} || iss_src2 !== {32'h60, 32'h50}) begin
         n_fail++; $display("FAIL age_pq_bypass got src1=%h src2=%h exp src1=%h src2=%h", iss_src1, iss_src2, {32'h99, 32'h99}, {32'h60, 32'h50}); end
      clear_inputs();
      step();
      n_checks++; if (iss_valid !== 2'b11 || iss_dest !== {5'd8, 5'd7}) begin
         n_fail++; $display("FAIL age_ef_dest got v=%b dest=%h exp v=11 dest=%h", iss_valid, iss_dest, {5'd8, 5'd7}); end
      step();
      n_checks++; if (iss_valid !== 2'b00 || free_cnt !== 4'd8) begin
         n_fail++; $display("FAIL age_drain got v=%b free=%0d exp v=00 free=8", iss_valid, free_cnt); end
   endtask

   task automatic test_cdb_capture();
      clear_inputs();
      disp_set(0, 6'd3, 32'h0, 5'd7, 32'h5, 5'd0, 5'd12);
      cdb_set(1, 5'd7, 32'h1234);
      step();
      n_checks++; if (iss_valid !== 2'b00) begin n_fail++; $display("FAIL cap_not_same_cycle got=%b exp=00", iss_valid); end
      clear_inputs();
      step();
      n_checks++; if (iss_valid !== 2'b01 || iss_src1[31:0] !== 32'h1234 || iss_src2[31:0] !== 32'h5) begin
         n_fail++; $display("FAIL cap_issue got v=%b src1=%h src2=%h exp v=01 src1=1234 src2=5", iss_valid, iss_src1[31:0], iss_src2[31:0]); end
      n_checks++; if (iss_pc[31:0] !== 32'h1030 || iss_reg[4:0] !== 5'd12 || iss_dest[4:0] !== 5'd12 || iss_op[5:0] !== 6'd3) begin
         n_fail++; $display("FAIL cap_payload got pc=%h reg=%0d dest=%0d op=%0d exp 1030/12/12/3", iss_pc[31:0], iss_reg[4:0], iss_dest[4:0], iss_op[5:0]); end
      n_checks++; if (iss_dest[9:5] !== 5'd0 || iss_src1[63:32] !== 32'd0) begin
         n_fail++; $display("FAIL cap_unused_port got dest=%0d src1=%h exp 0/0", iss_dest[9:5], iss_src1[63:32]); end
      step();
   endtask

   task automatic test_dup_tag();
      clear_inputs();
      disp_set(0, 6'd9, 32'h77, 5'd0, 32'h0, 5'd3, 5'd13);
      step();
      clear_inputs();
      cdb_set(0, 5'd3, 32'hA);
      cdb_set(2, 5'd3, 32'hB);
      cdb_tag[9:5] = 5'd3; cdb_data[63:32] = 32'hC;
      step();
      n_checks++; if (iss_valid !== 2'b01 || iss_src2[31:0] !== 32'hA) begin
         n_fail++; $display("FAIL dup_tag got v=%b src2=%h exp v=01 src2=a", iss_valid, iss_src2[31:0]); end
      clear_inputs();
      step();
   endtask

   task automatic test_fill();
      clear_inputs();
      for (int c = 0; c < 4; c++) begin
         clear_inputs();
         disp_set(0, 6'd1, 32'(c), 5'(16 + 2*c), 32'h0, 5'd0, 5'(1 + 2*c));
         disp_set(1, 6'd1, 32'(c), 5'(17 + 2*c), 32'h0, 5'd0, 5'(2 + 2*c));
         step();
         if (c == 2) begin
            n_checks++; if (free_cnt !== 4'd2 || disp_ready !== 1'b1) begin
               n_fail++; $display("FAIL fill_six got free=%0d rdy=%b exp 2/1", free_cnt, disp_ready); end
         end
      end
      n_checks++; if (free_cnt !== 4'd0 || disp_ready !== 1'b0) begin
         n_fail++; $display("FAIL fill_full got free=%0d rdy=%b exp 0/0", free_cnt, disp_ready); end
      clear_inputs();
      disp_set(0, 6'd2, 32'h1, 5'd0, 32'h2, 5'd0, 5'd30);
      disp_set(1, 6'd2, 32'h1, 5'd0, 32'h2, 5'd0, 5'd31);
      step();
      n_checks++; if (free_cnt !== 4'd0 || iss_valid !== 2'b00) begin
         n_fail++; $display("FAIL fill_ignore got free=%0d v=%b exp 0/00", free_cnt, iss_valid); end
      clear_inputs();
      cdb_set(0, 5'd16, 32'hF0);
      step();
      n_checks++; if (iss_valid !== 2'b01 || iss_dest[4:0] !== 5'd1 || free_cnt !== 4'd1 || disp_ready !== 1'b0) begin
         n_fail++; $display("FAIL fill_one_free got v=%b dest=%0d free=%0d rdy=%b exp 01/1/1/0", iss_valid, iss_dest[4:0], free_cnt, disp_ready); end
      clear_inputs();
      cdb_set(0, 5'd17, 32'h1);
      cdb_set(1, 5'd18, 32'h2);
      cdb_set(2, 5'd19, 32'h3);
      step();
      n_checks++; if (iss_valid !== 2'b11 || iss_dest !== {5'd3, 5'd2} || free_cnt !== 4'd3 || disp_ready !== 1'b1) begin
         n_fail++; $display("FAIL fill_two_oldest got v=%b dest=%h free=%0d rdy=%b exp 11/%h/3/1", iss_valid, iss_dest, free_cnt, disp_ready, {5'd3, 5'd2}); end
      clear_inputs();
      flush = 1'b1;
      step();
      clear_inputs();
   endtask

   task automatic test_flush_stall();
      clear_inputs();
      for (int c = 0; c < 3; c++) begin
         clear_inputs();
         disp_set(0, 6'd1, 32'h0, 5'd25, 32'h0, 5'd0, 5'(20 + c));
         if (c < 2) disp_set(1, 6'd1, 32'h0, 5'd25, 32'h0, 5'd0, 5'(24 + c));
         step();
      end
      n_checks++; if (free_cnt !== 4'd3) begin n_fail++; $display("FAIL flush_pre_free got=%0d exp=3", free_cnt); end
      clear_inputs();
      flush = 1'b1;
      disp_set(0, 6'd2, 32'h1, 5'd0, 32'h2, 5'd0, 5'd14);
      disp_set(1, 6'd2, 32'h1, 5'd0, 32'h2, 5'd0, 5'd15);
      cdb_set(0, 5'd25, 32'h55);
      step();
      n_checks++; if (free_cnt !== 4'd8 || iss_valid !== 2'b00) begin
         n_fail++; $display("FAIL flush_clear got free=%0d v=%b exp 8/00", free_cnt, iss_valid); end
      clear_inputs();
      step();
      n_checks++; if (free_cnt !== 4'd8 || iss_valid !== 2'b00) begin
         n_fail++; $display("FAIL flush_no_leak got free=%0d v=%b exp 8/00", free_cnt, iss_valid); end
      disp_set(0, 6'd4, 32'h21, 5'd0, 32'h0, 5'd0, 5'd21);
      disp_set(1, 6'd4, 32'h22, 5'd0, 32'h0, 5'd0, 5'd22);
      step();
      clear_inputs();
      iss_stall = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step();
         n_checks++; if (iss_valid !== 2'b00 || free_cnt !== 4'd6) begin
            n_fail++; $display("FAIL stall_hold%0d got v=%b free=%0d exp 00/6", c, iss_valid, free_cnt); end
      end
      iss_stall = 1'b0;
      step();
      n_checks++; if (iss_valid !== 2'b11 || iss_dest !== {5'd22, 5'd21} || free_cnt !== 4'd8) begin
         n_fail++; $display("FAIL stall_release got v=%b dest=%h free=%0d exp 11/%h/8", iss_valid, iss_dest, free_cnt, {5'd22, 5'd21}); end
      step();
   endtask

   task automatic test_rdy_hold();
      clear_inputs();
      rdy = 1'b0;
      disp_set(0, 6'd1, 32'h1, 5'd0, 32'h0, 5'd0, 5'd14);
      disp_set(1, 6'd1, 32'h2, 5'd0, 32'h0, 5'd0, 5'd15);
      step();
      n_checks++; if (free_cnt !== 4'd8) begin n_fail++; $display("FAIL rdy_low_disp got free=%0d exp=8", free_cnt); end
      rdy = 1'b1;
      step();
      n_checks++; if (free_cnt !== 4'd6) begin n_fail++; $display("FAIL rdy_high_disp got free=%0d exp=6", free_cnt); end
      disp_valid = '0;
      rdy = 1'b0;
      step();
      n_checks++; if (iss_valid !== 2'b00 || free_cnt !== 4'd6) begin
         n_fail++; $display("FAIL rdy_low_select got v=%b free=%0d exp 00/6", iss_valid, free_cnt); end
      rdy = 1'b1;
      step();
      n_checks++; if (iss_valid !== 2'b11 || iss_dest !== {5'd15, 5'd14} || free_cnt !== 4'd8) begin
         n_fail++; $display("FAIL rdy_issue got v=%b dest=%h free=%0d exp 11/%h/8", iss_valid, iss_dest, free_cnt, {5'd15, 5'd14}); end
      rdy = 1'b0;
      step();
      n_checks++; if (iss_valid !== 2'b11 || iss_dest !== {5'd15, 5'd14}) begin
         n_fail++; $display("FAIL rdy_out_hold got v=%b dest=%h exp 11/%h", iss_valid, iss_dest, {5'd15, 5'd14}); end
      rdy = 1'b1;
      step();
      n_checks++; if (iss_valid !== 2'b00) begin n_fail++; $display("FAIL rdy_resume got v=%b exp=00", iss_valid); end
   endtask

   task automatic test_reset_midstream();
      clear_inputs();
      disp_set(0, 6'd1, 32'h1, 5'd0, 32'h0, 5'd0, 5'd1);
      disp_set(1, 6'd1, 32'h2, 5'd0, 32'h0, 5'd0, 5'd2);
      step();
      clear_inputs();
      disp_set(0, 6'd1, 32'h3, 5'd30, 32'h0, 5'd0, 5'd3);
      disp_set(1, 6'd1, 32'h4, 5'd30, 32'h0, 5'd0, 5'd4);
      step();
      clear_inputs();
      n_checks++; if (iss_valid !== 2'b11 || free_cnt !== 4'd6) begin
         n_fail++; $display("FAIL mid_pre got v=%b free=%0d exp 11/6", iss_valid, free_cnt); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (iss_valid !== 2'b00 || free_cnt !== 4'd8 || disp_ready !== 1'b1 || iss_dest !== 10'd0) begin
         n_fail++; $display("FAIL mid_async_rst got v=%b free=%0d rdy=%b dest=%h exp 00/8/1/0", iss_valid, free_cnt, disp_ready, iss_dest); end
      #1 rst = 1'b0;
      step();
      n_checks++; if (iss_valid !== 2'b00 || free_cnt !== 4'd8) begin
         n_fail++; $display("FAIL mid_post got v=%b free=%0d exp 00/8", iss_valid, free_cnt); end
   endtask

   initial begin
      test_reset();
      test_age_order();
      test_cdb_capture();
      test_dup_tag();
      test_fill();
      test_flush_stall();
      test_rdy_hold();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
